mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single shared memory port of the processor. It grants the port to one requester at a time: requester 0 is the processor control unit's fetch/load/store/push/pop path, and requester 1 is the program loader/debug port. It drives the memory READ/WRITE strobes, address and write data for a fixed number of cycles, then returns read data with a one-cycle acknowledge. Arbitration is round-robin, so neither side can starve the other.

## Interface
Parameters:
- ADDR_W, 26, address width (matches jump-address field width)
- DATA_W, 32, data width (DATA_INDEX_LIMIT+1)
- LAT, 2, memory access cycles per transaction; legal range 1..15

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ0, REQ1  in  1  access request from requester 0 / 1
- WE0, WE1  in  1  1 = write, 0 = read
- ADDR0, ADDR1  in  ADDR_W  access address
- WDATA0, WDATA1  in  DATA_W  write data
- GNT0, GNT1  out  1  requester owns the port (held for the whole transaction)
- ACK0, ACK1  out  1  one-cycle completion pulse
- RDATA  out  DATA_W  read data, valid while ACKx=1
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDR  out  ADDR_W  memory address
- MEM_WDATA  out  DATA_W  memory write data
- MEM_RDATA  in  DATA_W  memory read data

## Operation
- States: IDLE, ACCESS, RESP. Reset enters IDLE.
- In IDLE, REQ0 and REQ1 are sampled.
  - If exactly one is high, that requester wins.
  - If both are high, the requester not granted last wins. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - The winner's WE, ADDR and WDATA are latched and GNTx is set. Next state is ACCESS, with the counter loaded to LAT-1.
- ACCESS:
  - MEM_ADDR and MEM_WDATA are driven from the latched values.
  - MEM_READ = ~WE or MEM_WRITE = WE is held for LAT cycles; the counter decrements each cycle.
  - In the cycle where the counter is 0, MEM_RDATA is captured (reads only) and the next state is RESP.
- RESP:
  - ACKx = 1 for exactly one cycle and RDATA holds the captured data. RDATA is unchanged for writes.
  - The strobes are 0. The pointer is updated to x and the next state is IDLE.
- GNTx is asserted from the IDLE->ACCESS edge through the end of the RESP cycle. GNT0 and GNT1 are never both 1.
- Input payload is latched at grant. Changes to REQ, ADDR or WDATA after grant are ignored.
- If REQ drops mid-transaction, the transaction still completes and ACK still pulses.
- REQ is ignored outside IDLE. A REQ still high in the IDLE cycle after RESP is treated as a new request.
- Reset values: GNTx=0, ACKx=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDR=0, MEM_WDATA=0, RDATA=0, state=IDLE, pointer=1.
- Reset asserted mid-transaction aborts it on that edge: strobes drop, and no ACK is issued.

## Timing
- All outputs are registered.
- REQ sampled in IDLE at edge 0 -> GNT and strobe go high after edge 1 -> strobes are held for LAT cycles -> ACK for one cycle -> IDLE.
- Request-to-ACK latency is LAT+1 cycles. The port is busy for LAT+2 cycles including the IDLE sampling cycle.
- Continuous back-to-back requests alternate strictly 0,1,0,1 when both are held high.
- With LAT=1, the strobe is high for exactly one cycle.

## Structure
- The shared project definitions package/header holds the state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), plus ADDR_W and DATA_W defaults.
- Natural sub-module: rr_pick2, a combinational two-way round-robin selector with inputs req[1:0] and last and outputs winner and valid. Everything else stays in mem_port_arbiter.

## Test plan
- Reset: hold RST high for 3 cycles with REQ0=REQ1=1 -> all outputs 0 and no GNT. Release -> GNT0 after the next edge.
- Single read: LAT=2, REQ0, WE0=0, ADDR0=0x0000010, memory returns 0xDEADBEEF -> MEM_READ high for 2 cycles with MEM_ADDR=0x10, then ACK0 with RDATA=0xDEADBEEF, 3 cycles after the request edge.
- Single write: REQ1, WE1=1, ADDR1=0x3FFFFFF, WDATA1=0x12345678 -> MEM_WRITE high for 2 cycles with those values, then ACK1. RDATA keeps its previous value.
- Contention: REQ0 and REQ1 held high for 8 transactions -> grant order 0,1,0,1,... and never both GNTs in any cycle.
- Payload stability: change ADDR0 from 0x10 to 0x20 and drop REQ0 one cycle after GNT0 -> MEM_ADDR stays 0x10 and ACK0 still pulses.
- Reset mid-op: assert RST during the first ACCESS cycle -> MEM_READ=0 after that edge, no ACK, pointer=1; the next tie goes to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared definitions for the memory port arbiter
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - two-way round-robin winner selector
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // A lone requester always wins; on a tie the side not served last wins.
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter and sequencer for the shared memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LAT    = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [DATA_W-1:0] RDATA,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    // Counter counts the remaining strobe cycles; LAT is limited to 1..15.
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    arb_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;

    logic              gnt0_d, gnt1_d, ack0_d, ack1_d;
    logic              rd_d, wr_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, rdata_d;

    logic              pick_winner, pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req    ({REQ1, REQ0}),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign sel_we    = pick_winner ? WE1    : WE0;
    assign sel_addr  = pick_winner ? ADDR1  : ADDR0;
    assign sel_wdata = pick_winner ? WDATA1 : WDATA0;

    // Next state and next values of every registered output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        gnt0_d  = GNT0;
        gnt1_d  = GNT1;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        rd_d    = MEM_READ;
        wr_d    = MEM_WRITE;
        addr_d  = MEM_ADDR;
        wdata_d = MEM_WDATA;
        rdata_d = RDATA;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                    owner_d = pick_winner;
                    gnt0_d  = ~pick_winner;
                    gnt1_d  = pick_winner;
                    rd_d    = ~sel_we;
                    wr_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    if (MEM_READ) begin
                        rdata_d = MEM_RDATA;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            GNT0      <= 1'b0;
            GNT1      <= 1'b0;
            ACK0      <= 1'b0;
            ACK1      <= 1'b0;
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            RDATA     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            GNT0      <= gnt0_d;
            GNT1      <= gnt1_d;
            ACK0      <= ack0_d;
            ACK1      <= ack1_d;
            MEM_READ  <= rd_d;
            MEM_WRITE <= wr_d;
            MEM_ADDR  <= addr_d;
            MEM_WDATA <= wdata_d;
            RDATA     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int ADDR_W = 26;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;

    logic              CLK, RST;
    logic              REQ0, REQ1, WE0, WE1;
    logic [ADDR_W-1:0] ADDR0, ADDR1;
    logic [DATA_W-1:0] WDATA0, WDATA1;
    logic              GNT0, GNT1, ACK0, ACK1;
    logic [DATA_W-1:0] RDATA;
    logic              MEM_READ, MEM_WRITE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA, MEM_RDATA;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant at edge s owns the port through edge s+LAT+1.
    int                edge_n   = 0;
    bit                m_valid  = 0;
    bit                m_active = 0;
    bit                m_fresh  = 1;
    int                m_start  = 0;
    bit                m_win    = 0;
    bit                m_last   = 1;
    bit                m_we     = 0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_wdata  = '0;
    logic [DATA_W-1:0] m_rdata  = '0;

    always @(posedge CLK) begin
        edge_n++;
        if (RST) begin
            m_valid  = 1;
            m_active = 0;
            m_fresh  = 1;
            m_last   = 1;
            m_addr   = '0;
            m_wdata  = '0;
            m_rdata  = '0;
        end else if (m_active) begin
            if (edge_n - m_start == LAT && !m_we) m_rdata = MEM_RDATA;
            if (edge_n - m_start == LAT + 1) begin
                m_active = 0;
                m_last   = m_win;
            end
        end else if (REQ0 || REQ1) begin
            m_win    = (REQ0 && REQ1) ? !m_last : REQ1;
            m_we     = m_win ? WE1 : WE0;
            m_addr   = m_win ? ADDR1 : ADDR0;
            m_wdata  = m_win ? WDATA1 : WDATA0;
            m_active = 1;
            m_fresh  = 0;
            m_start  = edge_n;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge CLK) begin
        if (m_valid) begin
            int  k;
            bit  strobe, ack;
            k      = edge_n - m_start;
            strobe = m_active && (k < LAT);
            ack    = m_active && (k == LAT);
            chk("m_gnt0", GNT0, m_active && !m_win);
            chk("m_gnt1", GNT1, m_active && m_win);
            chk("m_ack0", ACK0, ack && !m_win);
            chk("m_ack1", ACK1, ack && m_win);
            chk("m_read", MEM_READ, strobe && !m_we);
            chk("m_write", MEM_WRITE, strobe && m_we);
            chk("m_rdata", RDATA, m_rdata);
            chk("m_gnt_excl", GNT0 && GNT1, 0);
            if (strobe || m_fresh) begin
                chk("m_addr", MEM_ADDR, m_addr);
                chk("m_wdata", MEM_WDATA, m_wdata);
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 50; n++) begin
            cyc();
            if (!GNT0 && !GNT1) break;
        end
        if (n == 50) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int order[8];
        int got;
        int cycles;

        RST = 1; REQ0 = 1; REQ1 = 1; WE0 = 0; WE1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0; MEM_RDATA = '0;

        // Reset held with both requests high.
        repeat (3) begin
            cyc();
            chk("rst_gnt0", GNT0, 0);
            chk("rst_gnt1", GNT1, 0);
            chk("rst_read", MEM_READ, 0);
            chk("rst_rdata", RDATA, 0);
        end
        RST = 0;
        cyc();
        chk("rel_gnt0", GNT0, 1);
        chk("rel_gnt1", GNT1, 0);
        REQ0 = 0; REQ1 = 0;
        wait_idle();

        // Single read.
        REQ0 = 1; WE0 = 0; ADDR0 = 26'h10; MEM_RDATA = 32'hDEADBEEF;
        cyc();
        chk("rd_gnt0", GNT0, 1);
        chk("rd_strobe1", MEM_READ, 1);
        chk("rd_addr", MEM_ADDR, 26'h10);
        REQ0 = 0;
        cyc();
        chk("rd_strobe2", MEM_READ, 1);
        chk("rd_noack", ACK0, 0);
        cyc();
        chk("rd_ack0", ACK0, 1);
        chk("rd_strobe_off", MEM_READ, 0);
        chk("rd_rdata", RDATA, 32'hDEADBEEF);
        cyc();
        chk("rd_ack_pulse", ACK0, 0);
        chk("rd_gnt_off", GNT0, 0);

        // Single write.
        REQ1 = 1; WE1 = 1; ADDR1 = 26'h3FFFFFF; WDATA1 = 32'h12345678; MEM_RDATA = 32'h0BADF00D;
        cyc();
        chk("wr_gnt1", GNT1, 1);
        chk("wr_strobe1", MEM_WRITE, 1);
        chk("wr_noread", MEM_READ, 0);
        chk("wr_addr", MEM_ADDR, 26'h3FFFFFF);
        chk("wr_wdata", MEM_WDATA, 32'h12345678);
        REQ1 = 0;
        cyc();
        chk("wr_strobe2", MEM_WRITE, 1);
        cyc();
        chk("wr_ack1", ACK1, 1);
        chk("wr_rdata_kept", RDATA, 32'hDEADBEEF);
        wait_idle();

        // Contention: both held high, grants alternate starting with 0.
        REQ0 = 1; REQ1 = 1; WE0 = 0; WE1 = 1;
        got = 0;
        cycles = 0;
        while (got < 8 && cycles < 100) begin
            logic was_free;
            was_free = !GNT0 && !GNT1;
            cyc();
            cycles++;
            if (was_free && (GNT0 || GNT1)) begin
                order[got] = GNT1 ? 1 : 0;
                got++;
            end
        end
        chk("cont_count", got, 8);
        for (int i = 0; i < got; i++) chk("cont_order", order[i], i % 2);
        REQ0 = 0; REQ1 = 0;
        wait_idle();

        // Payload stability: address change and request drop after grant.
        REQ0 = 1; WE0 = 0; ADDR0 = 26'h10;
        cyc();
        chk("pay_gnt0", GNT0, 1);
        ADDR0 = 26'h20; REQ0 = 0;
        cyc();
        chk("pay_addr", MEM_ADDR, 26'h10);
        cyc();
        chk("pay_ack0", ACK0, 1);
        cyc();

        // Reset during the first access cycle.
        REQ0 = 1; WE0 = 0; ADDR0 = 26'h44;
        cyc();
        chk("mid_gnt0", GNT0, 1);
        RST = 1; REQ0 = 0;
        cyc();
        chk("mid_read", MEM_READ, 0);
        chk("mid_gnt0_off", GNT0, 0);
        chk("mid_ack0", ACK0, 0);
        RST = 0; REQ0 = 1; REQ1 = 1;
        cyc();
        chk("mid_tie_gnt0", GNT0, 1);
        REQ0 = 0; REQ1 = 0;
        wait_idle();

        // Random traffic, occasional reset.
        for (int i = 0; i < 3000; i++) begin
            RST       = ($urandom_range(0, 199) == 0);
            REQ0      = ($urandom_range(0, 3) != 0);
            REQ1      = ($urandom_range(0, 2) != 0);
            WE0       = $urandom_range(0, 1) == 1;
            WE1       = $urandom_range(0, 1) == 1;
            ADDR0     = ADDR_W'($urandom);
            ADDR1     = ADDR_W'($urandom);
            WDATA0    = $urandom;
            WDATA1    = $urandom;
            MEM_RDATA = $urandom;
            cyc();
        end
        RST = 0; REQ0 = 0; REQ1 = 0;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
